// File: rtl/crc32_stream_engine_pkg.sv
// crc_pkg: shared constants, FSM state type and bit-level helpers for the
// CRC-32 stream engine.
//   ETH_*          Ethernet CRC-32 polynomial, seed, output XOR and residue.
//   crc_state_e    frame state: IDLE, ACCUM, RESULT.
//   crc_step_bit   one serial LFSR step (MSB-first register, normal polynomial).
//   reflect32      bit reversal of a 32-bit word.
package crc_pkg;

   localparam logic [31:0] ETH_POLY    = 32'h04C11DB7;
   localparam logic [31:0] ETH_INIT    = 32'hFFFFFFFF;
   localparam logic [31:0] ETH_XOR_OUT = 32'hFFFFFFFF;
   localparam logic [31:0] ETH_RESIDUE = 32'hC704DD7B;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCUM  = 2'd1,
      RESULT = 2'd2
   } crc_state_e;

   function automatic logic [31:0] crc_step_bit(input logic [31:0] r,
                                                input logic        b,
                                                input logic [31:0] poly);
      logic inv;
      inv = b ^ r[31];
      return {r[30:0], 1'b0} ^ (inv ? poly : 32'h0);
   endfunction

   function automatic logic [31:0] reflect32(input logic [31:0] x);
      logic [31:0] y;
      for (int i = 0; i < 32; i++) y[i] = x[31-i];
      return y;
   endfunction

endpackage

// File: rtl/crc_parallel_update.sv
// crc_parallel_update: purely combinational one-beat CRC update.
// Unrolls the serial LFSR step over every enabled bit of a beat in wire order.
//   reg_in   current CRC register
//   data     beat; byte lane 0 (data[7:0]) is first on the wire
//   keep     per-lane enables (lane 0..KEEP_W-1); for DATA_W<8 keep[0]
//            gates the whole beat
//   reg_out  register after folding in the enabled bits
module crc_parallel_update
   import crc_pkg::*;
#(
   parameter int          DATA_W  = 8,
   parameter int          KEEP_W  = 1,
   parameter logic [31:0] POLY    = ETH_POLY,
   parameter bit          REFLECT = 1'b1
) (
   input  logic [31:0]       reg_in,
   input  logic [DATA_W-1:0] data,
   input  logic [KEEP_W-1:0] keep,
   output logic [31:0]       reg_out
);

   generate
      if (DATA_W < 8) begin : g_sub_byte
         // Sub-byte beats carry consecutive bits of a byte: with REFLECT the
         // low bit goes first, otherwise the high bit.
         logic [31:0] acc;
         always_comb begin
            acc = reg_in;
            for (int i = 0; i < DATA_W; i++)
               acc = crc_step_bit(acc, data[REFLECT ? i : DATA_W-1-i], POLY);
            reg_out = keep[0] ? acc : reg_in;
         end
      end else begin : g_lanes
         logic [31:0] acc;
         always_comb begin
            acc = reg_in;
            for (int l = 0; l < KEEP_W; l++) begin
               if (keep[l]) begin
                  for (int j = 0; j < 8; j++)
                     acc = crc_step_bit(acc, data[l*8 + (REFLECT ? j : 7-j)], POLY);
               end
            end
            reg_out = acc;
         end
      end
   endgenerate

endmodule

// File: rtl/crc32_stream_engine.sv
// crc32_stream_engine: parallel CRC-32 over a valid/ready beat stream.
// Emits one result per frame: the finished CRC and whether the raw register
// landed on the residue (so the same block generates and checks an FCS).
//   clk, rst_n     clock, asynchronous active-low reset
//   clear          synchronous frame abort (drops the frame, no result)
//   s_valid/ready  beat handshake; s_ready is low in RESULT and during clear
//   s_data/keep    beat and byte-lane enables (keep used on last beat, DATA_W>=16)
//   s_last         final beat of the frame
//   crc_valid      one-cycle result strobe
//   crc_out        out_map(reg ^ XOR_OUT), held until the next strobe
//   crc_ok         raw register equalled RESIDUE, held with crc_out
//   frame_len      byte count of the frame, saturating
//   busy           high from the first accepted beat through the result cycle
module crc32_stream_engine
   import crc_pkg::*;
#(
   parameter int          DATA_W  = 8,
   parameter logic [31:0] POLY    = ETH_POLY,
   parameter logic [31:0] INIT    = ETH_INIT,
   parameter logic [31:0] XOR_OUT = ETH_XOR_OUT,
   parameter bit          REFLECT = 1'b1,
   parameter logic [31:0] RESIDUE = ETH_RESIDUE,
   parameter int          LEN_W   = 16,
   localparam int         KEEP_W  = (DATA_W >= 8) ? DATA_W / 8 : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DATA_W-1:0] s_data,
   input  logic [KEEP_W-1:0] s_keep,
   input  logic              s_last,
   output logic              crc_valid,
   output logic [31:0]       crc_out,
   output logic              crc_ok,
   output logic [LEN_W-1:0]  frame_len,
   output logic              busy
);

   // The counter tracks bits so sub-byte widths round down naturally.
   localparam int CNT_W = LEN_W + 3;

   crc_state_e       state;
   logic [31:0]      crc_reg;
   logic [CNT_W-1:0] bit_cnt;
   logic [KEEP_W-1:0] lane_en;
   logic [CNT_W-1:0] beat_bits;
   logic [CNT_W-1:0] cnt_next;
   logic [31:0]      reg_upd;
   logic             accept;

   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [CNT_W-1:0] b);
      logic [CNT_W:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
   endfunction

   function automatic logic [31:0] out_map(input logic [31:0] x);
      return REFLECT ? reflect32(x) : x;
   endfunction

   assign s_ready = (state != RESULT) && !clear;
   assign accept  = s_valid && s_ready;

   always_comb begin
      lane_en = {KEEP_W{1'b1}};
      if (DATA_W >= 16 && s_last) lane_en = s_keep;
      if (DATA_W < 8) beat_bits = CNT_W'(DATA_W);
      else            beat_bits = CNT_W'($countones(lane_en)) << 3;
      cnt_next = sat_add(bit_cnt, beat_bits);
   end

   crc_parallel_update #(
      .DATA_W (DATA_W),
      .KEEP_W (KEEP_W),
      .POLY   (POLY),
      .REFLECT(REFLECT)
   ) u_update (
      .reg_in (crc_reg),
      .data   (s_data),
      .keep   (lane_en),
      .reg_out(reg_upd)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         crc_reg   <= INIT;
         bit_cnt   <= '0;
         busy      <= 1'b0;
         crc_valid <= 1'b0;
         crc_out   <= '0;
         crc_ok    <= 1'b0;
         frame_len <= '0;
      end else begin
         crc_valid <= 1'b0;
         if (clear) begin
            // Abort: result outputs keep their last values.
            state   <= IDLE;
            crc_reg <= INIT;
            bit_cnt <= '0;
            busy    <= 1'b0;
         end else begin
            unique case (state)
               IDLE, ACCUM: begin
                  if (accept) begin
                     crc_reg <= reg_upd;
                     bit_cnt <= cnt_next;
                     busy    <= 1'b1;
                     if (s_last) begin
                        // Results are captured here so they appear in RESULT.
                        state     <= RESULT;
                        crc_valid <= 1'b1;
                        crc_out   <= out_map(reg_upd ^ XOR_OUT);
                        crc_ok    <= (reg_upd == RESIDUE);
                        frame_len <= LEN_W'(cnt_next >> 3);
                     end else begin
                        state <= ACCUM;
                     end
                  end
               end
               RESULT: begin
                  state   <= IDLE;
                  crc_reg <= INIT;
                  bit_cnt <= '0;
                  busy    <= 1'b0;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: doc/crc32_stream_engine.md
Name: crc32_stream_engine

Overview:
Parametrised CRC-32 engine for the Ethernet MAC datapath. It processes DATA_W bits per beat over a valid/ready stream and supports partial last beats. It reports the final CRC once per frame, along with a residue check so the same block serves both TX FCS generation and RX FCS checking. It sits between the byte/word framer and the MAC TX/RX controllers, and replaces bit-serial CRC update where more than one bit arrives per clock.

Parameters:
DATA_W, 8, bits per beat; legal values 1, 2, 4, 8, 16, 32, 64.
POLY, 32'h04C11DB7, generator polynomial in normal (MSB-first) form.
INIT, 32'hFFFFFFFF, register value at frame start.
XOR_OUT, 32'hFFFFFFFF, XOR applied to the register to form crc_out.
REFLECT, 1, 1 = bit 0 of each byte enters first (Ethernet) and crc_out is bit-reversed; 0 = MSB first, no reversal.
RESIDUE, 32'hC704DD7B, raw register value expected after data plus a correct FCS.
LEN_W, 16, width of the byte counter.

Ports:
clk  in  1  clock; all logic on the rising edge.
rst_n  in  1  asynchronous active-low reset.
clear  in  1  synchronous frame abort; highest priority after reset.
s_valid  in  1  input beat valid.
s_ready  out  1  engine can accept a beat.
s_data  in  DATA_W  input beat; byte lane 0 = s_data[7:0] is first on the wire.
s_keep  in  max(1,DATA_W/8)  byte-lane enables; honoured only on the last beat when DATA_W>=16, otherwise ignored (all lanes valid).
s_last  in  1  beat is the final one of the frame.
crc_valid  out  1  one-cycle pulse: result outputs are valid.
crc_out  out  32  final CRC = out_map(reg ^ XOR_OUT), held until the next crc_valid.
crc_ok  out  1  raw register equalled RESIDUE at frame end; held with crc_out.
frame_len  out  LEN_W  bytes in the frame (bits/8 rounded down when DATA_W<8), saturating at all-ones.
busy  out  1  high from first accepted beat until crc_valid.

Behaviour:
- Reset: reg=INIT, state=IDLE, s_ready=1, crc_valid=0, crc_out=0, crc_ok=0, frame_len=0, busy=0, byte counter=0.
- States:
  - IDLE: s_ready=1; an accepted beat (s_valid&&s_ready) goes to ACCUM, or to RESULT if s_last=1.
  - ACCUM: s_ready=1; accepted beats update reg; accepted beat with s_last goes to RESULT.
  - RESULT: exactly one cycle. s_ready=0, crc_valid=1, outputs registered. reg reloads INIT and the counter clears, then go to IDLE.
- Update: reg_next = fold over the enabled bits of the beat, in wire order, of the serial step: inv=bit^reg[31]; reg={reg[30:0],1'b0} ^ (inv ? POLY : 0).
  - Fully combinational unrolled loop; one beat per cycle; no throughput loss inside a frame.
  - Peak rate is one frame per (beats+1) cycles.
- Partial last beat: only lanes 0..k enabled. s_keep must be contiguous from lane 0; non-contiguous keep is undefined. Bench asserts s_keep[0]=1 on any last beat.
- Latency: crc_valid asserts the cycle after the last beat is accepted.
- Count: increments by popcount(s_keep) (or DATA_W/8, or the accumulated bit count /8 for DATA_W<8) per accepted beat; saturates, never wraps.
- clear: from any state, next cycle is IDLE with reg=INIT and counter=0. No crc_valid is issued. crc_out, crc_ok and frame_len keep their previous values.
  - clear coinciding with an s_last beat wins: the frame is dropped.
  - A beat presented with clear is not consumed: s_ready=0 while clear=1.
- Single-beat frame (s_last on first beat) is legal: IDLE goes straight to RESULT.
- s_valid during RESULT is stalled, not dropped. Upstream holds s_data, s_keep and s_last stable until accepted.
- Async reset mid-frame discards all state immediately.

Decomposition:
- Package crc_pkg:
  - ETH_POLY, ETH_INIT, ETH_XOR_OUT, ETH_RESIDUE constants.
  - crc_state_e enum {IDLE, ACCUM, RESULT}.
  - Functions crc_step_bit(reg,bit) and reflect32(x).
- Sub-module crc_parallel_update: purely combinational (reg_in, data, keep) -> reg_out. The FSM, counter and output registers stay in crc32_stream_engine.

Test Plan:
- DATA_W=8, ASCII "123456789" (0x31..0x39), s_last on 0x39 -> crc_valid one cycle later, crc_out=32'hCBF43926, frame_len=9.
- DATA_W=8, same nine bytes followed by FCS 0x26,0x39,0xF4,0xCB -> crc_ok=1, frame_len=13. Flip one data bit -> crc_ok=0.
- DATA_W=32, "123456789" as three beats, last beat s_keep=4'b0001 -> crc_out=32'hCBF43926. Repeat with s_valid gaps -> identical result.
- DATA_W=4 (MII nibbles, low nibble first), 60-byte random frame -> crc_out matches the DATA_W=8 instance fed the same bytes.
- clear pulsed on the 5th beat, then a full "123456789" frame -> no crc_valid for the aborted frame; second frame gives 32'hCBF43926, frame_len=9.
- Back-to-back single-beat frames with s_valid held high -> s_ready low only in each RESULT cycle. Each crc_valid is separated by exactly one cycle, with correct per-frame CRCs. rst_n asserted mid-frame -> all outputs return to reset values asynchronously.
